// File: rtl/sdc_dmaster_bytes_to_packets.sv
`default_nettype none
// ============================================================================
// Module   : sdc_dmaster_bytes_to_packets
// Purpose  : Decodes the debug-master raw byte stream into Avalon-ST packets.
//            In-band SOP, EOP, channel-prefix and escape characters are
//            stripped. Each remaining data byte is presented on a single
//            registered output stage that carries SOP/EOP/channel sideband.
// Ports    : clk, reset           - clock, synchronous active-high reset
//            in_valid/in_ready    - raw byte sink handshake
//            in_data[7:0]         - raw byte
//            out_valid/out_ready  - decoded beat source handshake
//            out_data[7:0]        - decoded byte
//            out_channel          - channel of the beat
//            out_startofpacket    - SOP qualifier
//            out_endofpacket      - EOP qualifier
// Revision : 1.0  initial release
// ============================================================================
module sdc_dmaster_bytes_to_packets #(
  parameter int         CHANNEL_WIDTH = 8,
  parameter logic [7:0] SOP_CHAR      = 8'h7A,
  parameter logic [7:0] EOP_CHAR      = 8'h7B,
  parameter logic [7:0] CHAN_CHAR     = 8'h7C,
  parameter logic [7:0] ESC_CHAR      = 8'h7D,
  parameter logic [7:0] ESC_XOR       = 8'h20
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     in_ready,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [7:0]               out_data,
  output logic [CHANNEL_WIDTH-1:0] out_channel,
  output logic                     out_startofpacket,
  output logic                     out_endofpacket
);

  // Decoder state: pending flags plus the channel for the next emitted byte.
  logic                     esc_pend;
  logic                     chan_pend;
  logic                     sop_pend;
  logic                     eop_pend;
  logic [CHANNEL_WIDTH-1:0] channel;

  logic                     esc_pend_nx;
  logic                     chan_pend_nx;
  logic                     sop_pend_nx;
  logic                     eop_pend_nx;
  logic [CHANNEL_WIDTH-1:0] channel_nx;

  logic                     accept;
  logic                     emit;
  logic [7:0]               dec_byte;
  logic [CHANNEL_WIDTH-1:0] dec_chan;

  // The output stage can take a new beat when empty or draining this cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // An escaped byte is un-XORed; otherwise the byte is taken as-is. Only the
  // branches that see esc_pend=1 or a non-control byte use this value.
  assign dec_byte = esc_pend ? (in_data ^ ESC_XOR) : in_data;

  generate
    if (CHANNEL_WIDTH <= 8) begin : g_chan_trunc
      assign dec_chan = dec_byte[CHANNEL_WIDTH-1:0];
    end else begin : g_chan_zext
      assign dec_chan = {{(CHANNEL_WIDTH-8){1'b0}}, dec_byte};
    end
  endgenerate

  // Byte decode, evaluated in priority order. An escape pending makes the
  // following byte literal, even if it matches a control character.
  always_comb begin
    esc_pend_nx  = esc_pend;
    chan_pend_nx = chan_pend;
    sop_pend_nx  = sop_pend;
    eop_pend_nx  = eop_pend;
    channel_nx   = channel;
    emit         = 1'b0;

    if (accept) begin
      if (esc_pend) begin
        esc_pend_nx = 1'b0;
        if (chan_pend) begin
          channel_nx   = dec_chan;
          chan_pend_nx = 1'b0;
        end else begin
          emit = 1'b1;
        end
      end else if (in_data == ESC_CHAR) begin
        esc_pend_nx = 1'b1;
      end else if (in_data == SOP_CHAR) begin
        // A framing marker cancels a pending channel prefix; channel holds.
        sop_pend_nx  = 1'b1;
        chan_pend_nx = 1'b0;
      end else if (in_data == EOP_CHAR) begin
        eop_pend_nx  = 1'b1;
        chan_pend_nx = 1'b0;
      end else if (in_data == CHAN_CHAR) begin
        chan_pend_nx = 1'b1;
      end else if (chan_pend) begin
        channel_nx   = dec_chan;
        chan_pend_nx = 1'b0;
      end else begin
        emit = 1'b1;
      end
    end

    // The framing flags are consumed by the byte that carries them.
    if (emit) begin
      sop_pend_nx = 1'b0;
      eop_pend_nx = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      esc_pend          <= 1'b0;
      chan_pend         <= 1'b0;
      sop_pend          <= 1'b0;
      eop_pend          <= 1'b0;
      channel           <= '0;
      out_valid         <= 1'b0;
      out_data          <= 8'h00;
      out_channel       <= '0;
      out_startofpacket <= 1'b0;
      out_endofpacket   <= 1'b0;
    end else begin
      esc_pend  <= esc_pend_nx;
      chan_pend <= chan_pend_nx;
      sop_pend  <= sop_pend_nx;
      eop_pend  <= eop_pend_nx;
      channel   <= channel_nx;

      // emit implies accept, which implies the register is free or draining.
      if (emit) begin
        out_valid         <= 1'b1;
        out_data          <= dec_byte;
        out_channel       <= channel;
        out_startofpacket <= sop_pend;
        out_endofpacket   <= eop_pend;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sdc_dmaster_bytes_to_packets.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdc_dmaster_bytes_to_packets
// Purpose  : Self-checking bench for sdc_dmaster_bytes_to_packets. A
//            cycle-level behavioural model predicts every output each cycle;
//            directed sequences additionally pin exact beat lists.
// Revision : 1.0  initial release
// ============================================================================
module tb_sdc_dmaster_bytes_to_packets;

  localparam int CW = 8;

  logic          clk;
  logic          reset;
  logic          in_ready;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          out_ready;
  logic          out_valid;
  logic [7:0]    out_data;
  logic [CW-1:0] out_channel;
  logic          out_startofpacket;
  logic          out_endofpacket;

  sdc_dmaster_bytes_to_packets #(.CHANNEL_WIDTH(CW)) dut (
    .clk               (clk),
    .reset             (reset),
    .in_ready          (in_ready),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .out_ready         (out_ready),
    .out_valid         (out_valid),
    .out_data          (out_data),
    .out_channel       (out_channel),
    .out_startofpacket (out_startofpacket),
    .out_endofpacket   (out_endofpacket)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Beats seen on the DUT and predicted by the model: {data, channel, sop, eop}
  logic [17:0] dut_q[$];
  logic [17:0] mdl_q[$];

  // ---------------- behavioural model state ----------------
  logic       m_valid, m_sop_o, m_eop_o, m_after_reset;
  logic [7:0] m_data, m_ch_o, m_chan;
  logic       m_esc, m_cp, m_sp, m_ep;
  logic       chk_en = 1'b0;

  // ---------------- out_ready generator ----------------
  int         rdy_mode = 0;
  int         cyc = 0;
  logic [3:0] pat = 4'b1001;   // bit0 first: 1,0,0,1

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      case (rdy_mode)
        1:       out_ready = pat[cyc % 4];
        2:       out_ready = ($urandom_range(0, 2) != 0);
        default: out_ready = 1'b1;
      endcase
      cyc++;
    end
  end

  // ---------------- compare + predict process ----------------
  initial begin
    logic       acc, emit;
    logic [7:0] b, v;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        checks++;
        if (out_valid !== m_valid) begin
          failures++;
          $display("FAIL out_valid actual=%b expected=%b t=%0t", out_valid, m_valid, $time);
        end
        checks++;
        if (in_ready !== (!m_valid || out_ready)) begin
          failures++;
          $display("FAIL in_ready actual=%b expected=%b t=%0t", in_ready, (!m_valid || out_ready), $time);
        end
        if (m_valid || m_after_reset) begin
          checks++;
          if ({out_data, out_channel, out_startofpacket, out_endofpacket} !== {m_data, m_ch_o, m_sop_o, m_eop_o}) begin
            failures++;
            $display("FAIL beat_fields actual=%h/%h/%b/%b expected=%h/%h/%b/%b t=%0t",
                     out_data, out_channel, out_startofpacket, out_endofpacket,
                     m_data, m_ch_o, m_sop_o, m_eop_o, $time);
          end
        end
        if (out_valid && out_ready)
          dut_q.push_back({out_data, out_channel, out_startofpacket, out_endofpacket});
        if (m_valid && out_ready)
          mdl_q.push_back({m_data, m_ch_o, m_sop_o, m_eop_o});
      end

      // Predict the state after the coming rising edge.
      if (reset) begin
        m_valid = 0; m_data = 0; m_ch_o = 0; m_sop_o = 0; m_eop_o = 0;
        m_esc = 0; m_cp = 0; m_sp = 0; m_ep = 0; m_chan = 0;
        m_after_reset = 1;
        chk_en = 1;
      end else begin
        m_after_reset = 0;
        acc  = in_valid && (!m_valid || out_ready);
        emit = 0;
        v    = 8'h00;
        if (acc) begin
          b = in_data;
          if (m_esc) begin
            v = b ^ 8'h20;
            m_esc = 0;
            if (m_cp) begin m_chan = v; m_cp = 0; end
            else emit = 1;
          end else if (b == 8'h7D) m_esc = 1;
          else if (b == 8'h7A) begin m_sp = 1; m_cp = 0; end
          else if (b == 8'h7B) begin m_ep = 1; m_cp = 0; end
          else if (b == 8'h7C) m_cp = 1;
          else if (m_cp) begin m_chan = b; m_cp = 0; end
          else begin emit = 1; v = b; end
        end
        if (emit) begin
          m_valid = 1; m_data = v; m_ch_o = m_chan;
          m_sop_o = m_sp; m_eop_o = m_ep;
          m_sp = 0; m_ep = 0;
        end else if (out_ready) begin
          m_valid = 0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Entry and exit: 2 time units after a rising edge.
  task automatic send(input logic [7:0] b);
    int   n;
    logic ok;
    n = 0;
    in_data  = b;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #2;
      n++;
    end while (!ok && n < 50);
    in_valid = 1'b0;
    if (!ok) begin
      checks++; failures++;
      $display("FAIL send_timeout byte=%h in_ready stayed 0 for %0d cycles", b, n);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    dut_q.delete();
    mdl_q.delete();
  endtask

  task automatic expect_beat(input string nm, input logic [7:0] d, input logic [7:0] ch,
                             input logic s, input logic e);
    logic [17:0] want, got;
    want = {d, ch, s, e};
    checks++;
    if (dut_q.size() == 0) begin
      failures++; $display("FAIL %s dut beat missing expected=%h", nm, want);
    end else begin
      got = dut_q.pop_front();
      if (got !== want) begin
        failures++; $display("FAIL %s dut beat actual=%h expected=%h", nm, got, want);
      end
    end
    checks++;
    if (mdl_q.size() == 0) begin
      failures++; $display("FAIL %s model beat missing expected=%h", nm, want);
    end else begin
      got = mdl_q.pop_front();
      if (got !== want) begin
        failures++; $display("FAIL %s model beat actual=%h expected=%h", nm, got, want);
      end
    end
  endtask

  task automatic expect_none(input string nm);
    checks++;
    if (dut_q.size() != 0) begin
      failures++; $display("FAIL %s extra dut beats actual=%0d expected=0", nm, dut_q.size());
    end
  endtask

  task automatic send_list(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send(bytes[i]);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(posedge clk); #2;
    reset = 1'b0;
    dut_q.delete(); mdl_q.delete();

    // Basic framing
    send_list('{8'h7A, 8'h7C, 8'h00, 8'h11, 8'h22, 8'h7B, 8'h33});
    idle(3);
    expect_beat("framing0", 8'h11, 8'h00, 1, 0);
    expect_beat("framing1", 8'h22, 8'h00, 0, 0);
    expect_beat("framing2", 8'h33, 8'h00, 0, 1);
    expect_none("framing");

    // Escaping
    do_reset();
    send_list('{8'h7A, 8'h7D, 8'h5A, 8'h7D, 8'h5D, 8'h7B, 8'h7D, 8'h5B});
    idle(3);
    expect_beat("escape0", 8'h7A, 8'h00, 1, 0);
    expect_beat("escape1", 8'h7D, 8'h00, 0, 0);
    expect_beat("escape2", 8'h7B, 8'h00, 0, 1);
    expect_none("escape");

    // Channel switch
    do_reset();
    send_list('{8'h7C, 8'h03, 8'h7A, 8'hAA, 8'h7B, 8'hBB,
                8'h7C, 8'h7D, 8'h5C, 8'h7A, 8'hCC});
    idle(3);
    expect_beat("chan0", 8'hAA, 8'h03, 1, 0);
    expect_beat("chan1", 8'hBB, 8'h03, 0, 1);
    expect_beat("chan2", 8'hCC, 8'h7C, 1, 0);
    expect_none("chan");

    // Backpressure with out_ready 1,0,0,1 repeating
    do_reset();
    rdy_mode = 1;
    send_list('{8'h7A, 8'h01, 8'h02, 8'h7B, 8'h03});
    rdy_mode = 0;
    idle(5);
    expect_beat("bp0", 8'h01, 8'h00, 1, 0);
    expect_beat("bp1", 8'h02, 8'h00, 0, 0);
    expect_beat("bp2", 8'h03, 8'h00, 0, 1);
    expect_none("bp");

    // Single-byte packet, then reset in the middle of an escape
    do_reset();
    send_list('{8'h7B, 8'h7A, 8'h44});
    idle(3);
    expect_beat("single", 8'h44, 8'h00, 1, 1);
    send(8'h7D);
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00) begin
      failures++;
      $display("FAIL post_reset actual=%b/%h expected=0/00", out_valid, out_data);
    end
    @(posedge clk); #2;
    dut_q.delete(); mdl_q.delete();
    send_list('{8'h7A, 8'h55});
    idle(3);
    expect_beat("reset_esc", 8'h55, 8'h00, 1, 0);
    expect_none("reset_esc");

    // Randomized traffic, backpressure and occasional resets
    rdy_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0:       in_data = 8'h7A;
        1:       in_data = 8'h7B;
        2:       in_data = 8'h7C;
        3, 4:    in_data = 8'h7D;
        5:       in_data = 8'h5A + 8'($urandom_range(0, 3));
        default: in_data = 8'($urandom);
      endcase
      reset = ($urandom_range(0, 199) == 0);
      @(posedge clk); #2;
    end
    reset = 1'b0;
    in_valid = 1'b0;
    rdy_mode = 0;
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/sdc_dmaster_bytes_to_packets.md
Name: sdc_dmaster_bytes_to_packets

Overview:
- Decodes the raw byte stream from the debug-master transport into Avalon-ST packets with SOP, EOP and channel sideband.
- Sits directly upstream of the debug-master channel adapter, which consumes its data, channel and SOP/EOP outputs.
- Strips the in-band control characters: SOP, EOP, channel prefix and escape.
- Registered single-stage output with backpressure.

Parameters:
- CHANNEL_WIDTH, 8, width of out_channel; the channel byte is truncated to its low CHANNEL_WIDTH bits.
- SOP_CHAR, 8'h7A, start-of-packet marker.
- EOP_CHAR, 8'h7B, end-of-packet marker; the next data byte is the last byte of the packet.
- CHAN_CHAR, 8'h7C, channel marker; the next decoded byte is the channel number.
- ESC_CHAR, 8'h7D, escape marker; the next byte is XORed with ESC_XOR.
- ESC_XOR, 8'h20, escape XOR mask.

Ports:
- clk  input  1  single clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in_ready  output  1  byte-stream sink ready.
- in_valid  input  1  byte valid.
- in_data  input  8  raw byte.
- out_ready  input  1  downstream ready (from the channel adapter).
- out_valid  output  1  decoded data byte valid.
- out_data  output  8  decoded byte.
- out_channel  output  CHANNEL_WIDTH  current channel.
- out_startofpacket  output  1  SOP qualifier.
- out_endofpacket  output  1  EOP qualifier.

Behaviour:
- Reset (synchronous, active-high, clk edge): out_valid=0, out_data=0, out_channel=0, out_sop=0, out_eop=0. Internal flags cleared: esc_pend, chan_pend, sop_pend, eop_pend.
- Reset mid-packet or mid-escape discards all partial state. No output is produced in the reset cycle.
- in_ready = !out_valid || out_ready (combinational). A byte is accepted when in_valid && in_ready. Control bytes are accepted under the same rule.
- Output register: on out_valid && out_ready with no new emit, out_valid goes to 0 next cycle. On out_valid && !out_ready, all out_* hold stable.
- Decode of an accepted byte b, evaluated in priority order:
  1. esc_pend=1: v = b ^ ESC_XOR. Clear esc_pend. If chan_pend, set channel=v and clear chan_pend; otherwise emit v. Control characters are literal in this case.
  2. b==ESC_CHAR: set esc_pend.
  3. b==SOP_CHAR: set sop_pend. If chan_pend, clear it and leave channel unchanged.
  4. b==EOP_CHAR: set eop_pend. Same chan_pend rule as SOP_CHAR.
  5. b==CHAN_CHAR: set chan_pend. A repeated CHAN_CHAR keeps chan_pend set.
  6. chan_pend=1: channel = b[CHANNEL_WIDTH-1:0]; clear chan_pend.
  7. Otherwise: emit b.
- Emit v: next cycle out_valid=1, out_data=v, out_channel=channel register, out_sop=sop_pend, out_eop=eop_pend. Clear sop_pend and eop_pend in the same edge.
- Latency: exactly 1 cycle from data-byte acceptance to out_valid.
- Throughput: 1 byte/cycle while out_ready=1.
- A channel update takes effect on the next emitted byte. Bytes already in the output register keep their channel.
- SOP_CHAR followed by EOP_CHAR (either order) before one data byte gives a single-byte packet with sop=eop=1.
- Repeated SOP_CHAR or EOP_CHAR before data is idempotent.
- EOP_CHAR then SOP_CHAR is not reordered; both flags land on the next byte.
- The block does no packet-framing checks. Missing SOP/EOP pass through as-is.
- Channels above the downstream maximum are emitted unchanged; filtering is the channel adapter's job.
- esc_pend survives stalls. It is cleared only by the next accepted byte or by reset.

Test Plan:
- Basic framing: bytes 7A 7C 00 11 22 7B 33, out_ready=1.
  Required: 3 beats, data 11/22/33, channel 0; sop on 11 only, eop on 33 only; each beat 1 cycle after its input is accepted.
- Escaping: 7A 7D 5A 7D 5D 7B 7D 5B.
  Required: data 7A, 7D, 7B; sop on first beat, eop on last; no beat for any marker byte.
- Channel switch: 7C 03 7A AA 7B BB, then 7C 7D 5C 7A CC.
  Required: AA/BB on channel 3; CC on channel 0x7C with sop=1.
- Backpressure: stream 7A 01 02 7B 03 with out_ready toggling 1,0,0,1.
  Required: in_ready=0 while a beat is held; out_data/flags stable during the stall; no byte lost or duplicated; order 01,02,03.
- Single-byte packet and reset: 7B 7A 44 gives data 44 with sop=eop=1.
  Then 7D followed by reset asserted one cycle: next byte 7A is treated as SOP_CHAR, not escaped data; out_valid=0 in the cycle after reset.
